// File: rtl/trap_sequencer.sv
// User-mode trap/URET sequencer: drives the CSR file's write port and redirects fetch.
// Optional `TRAP_INTERRUPT_EN adds user external interrupts with vectored utvec support.
module trap_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [11:0] ADDR_USTATUS = 12'h000,
    parameter logic [11:0] ADDR_UEPC    = 12'h041,
    parameter logic [11:0] ADDR_UCAUSE  = 12'h042,
    parameter logic [11:0] ADDR_UTVAL   = 12'h043
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    input  logic [XLEN-1:0] iPC,
    input  logic [XLEN-1:0] iInst,
    input  logic            iIllegal,
    input  logic            iEcall,
    input  logic            iLoadMis,
    input  logic            iStoreMis,
    input  logic [XLEN-1:0] iBadAddr,
    input  logic            iUret,
    input  logic [XLEN-1:0] iUSTATUS,
    input  logic [XLEN-1:0] iUTVEC,
    input  logic [XLEN-1:0] iUEPC,
    input  logic            iExtIrq,
    input  logic            iUIE_UEIE,
    output logic            oCSRWe,
    output logic [11:0]     oCSRAddr,
    output logic [XLEN-1:0] oCSRData,
    output logic            oStall,
    output logic            oRedirect,
    output logic [XLEN-1:0] oRedirectPC,
    output logic            oBusy
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIRECT
    } state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_epc, r_cause, r_tval, r_target;
    logic            r_irq;

    logic            w_exc, w_irq, w_trap, w_uret;
    logic [XLEN-1:0] w_cause, w_tval, w_base, w_vec_target;

    // Detection is gated by reset so every output reads 0 while iRST is high.
    assign w_exc  = ~iRST & iValid & (iIllegal | iEcall | iLoadMis | iStoreMis);
`ifdef TRAP_INTERRUPT_EN
    assign w_irq  = ~iRST & iValid & iExtIrq & iUIE_UEIE & iUSTATUS[0] & ~w_exc;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{iExtIrq, iUIE_UEIE, iUTVEC[1:0]};
    assign w_irq  = 1'b0;
`endif
    assign w_trap = (r_state == IDLE) & (w_exc | w_irq);
    assign w_uret = (r_state == IDLE) & ~iRST & iValid & iUret & ~w_exc & ~w_irq;

    always_comb begin
        w_cause = '0;
        w_tval  = '0;
        if (iIllegal) begin
            w_cause = XLEN'(2);
            w_tval  = iInst;
        end else if (iEcall) begin
            w_cause = XLEN'(8);
        end else if (iLoadMis) begin
            w_cause = XLEN'(4);
            w_tval  = iBadAddr;
        end else if (iStoreMis) begin
            w_cause = XLEN'(6);
            w_tval  = iBadAddr;
        end else if (w_irq) begin
            w_cause = {1'b1, {(XLEN-5){1'b0}}, 4'h8};
        end
    end

    assign w_base = {iUTVEC[XLEN-1:2], 2'b00};
`ifdef TRAP_INTERRUPT_EN
    assign w_vec_target = (r_irq && iUTVEC[1:0] == 2'b01) ? w_base + XLEN'(32) : w_base;
`else
    assign w_vec_target = w_base;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_tval   <= '0;
            r_target <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_trap) begin
                r_epc   <= iPC;
                r_cause <= w_cause;
                r_tval  <= w_tval;
                r_irq   <= w_irq;
            end else if (w_uret) begin
                r_target <= iUEPC;
            end
            if (r_state == W_STATUS) r_target <= w_vec_target;
        end
    end

    always_comb begin
        w_next      = r_state;
        oCSRWe      = 1'b0;
        oCSRAddr    = '0;
        oCSRData    = '0;
        oRedirect   = 1'b0;
        oRedirectPC = '0;
        case (r_state)
            IDLE: begin
                if (w_trap)      w_next = W_EPC;
                else if (w_uret) w_next = R_STATUS;
            end
            W_EPC: begin
                oCSRWe   = 1'b1;
                oCSRAddr = ADDR_UEPC;
                oCSRData = {r_epc[XLEN-1:2], 2'b00};
                w_next   = W_CAUSE;
            end
            W_CAUSE: begin
                oCSRWe   = 1'b1;
                oCSRAddr = ADDR_UCAUSE;
                oCSRData = r_cause;
                w_next   = W_TVAL;
            end
            W_TVAL: begin
                oCSRWe   = 1'b1;
                oCSRAddr = ADDR_UTVAL;
                oCSRData = r_tval;
                w_next   = W_STATUS;
            end
            W_STATUS: begin
                // UPIE <= UIE, UIE <= 0
                oCSRWe   = 1'b1;
                oCSRAddr = ADDR_USTATUS;
                oCSRData = {iUSTATUS[XLEN-1:5], iUSTATUS[0], iUSTATUS[3:1], 1'b0};
                w_next   = REDIRECT;
            end
            R_STATUS: begin
                // UIE <= UPIE, UPIE <= 1
                oCSRWe   = 1'b1;
                oCSRAddr = ADDR_USTATUS;
                oCSRData = {iUSTATUS[XLEN-1:5], 1'b1, iUSTATUS[3:1], iUSTATUS[4]};
                w_next   = REDIRECT;
            end
            REDIRECT: begin
                oRedirect   = 1'b1;
                oRedirectPC = r_target;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign oBusy  = (r_state != IDLE);
    assign oStall = oBusy | w_trap | w_uret;

endmodule
